// File: rtl/usb_stream_in_ep.sv
// rtl/usb_stream_in_ep.sv - streaming IN endpoint: packetises a byte stream onto the PE in_ep_* interface
module usb_stream_in_ep #(
    parameter int MAX_PACKET   = 64,
    parameter int CNT_W        = 7,
    parameter int FLUSH_CYCLES = 4800
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    input  logic       flush,
    input  logic       stall,
    output logic       in_ep_req,
    input  logic       in_ep_grant,
    input  logic       in_ep_data_free,
    output logic       in_ep_data_put,
    output logic [7:0] in_ep_data,
    output logic       in_ep_data_done,
    output logic       in_ep_stall,
    input  logic       in_ep_acked,
    output logic       busy
);

    localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_PACKET);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MAX_PACKET - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_DONE,
        S_WAIT_ACK
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              flush_pend;
    logic              last_full;
    logic              zlp;
    logic              put;

    // A pending flush on a non-empty packet closes it before any further byte is taken.
    always_comb begin
        src_ready = 1'b0;
        if (state == S_FILL) begin
            src_ready = in_ep_grant && in_ep_data_free && (cnt < MAX_CNT) &&
                        !(flush_pend && (cnt != '0));
        end
        put            = src_valid && src_ready;
        in_ep_data_put = put;
        in_ep_data     = put ? src_data : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            idle_cnt        <= '0;
            flush_pend      <= 1'b0;
            last_full       <= 1'b0;
            zlp             <= 1'b0;
            in_ep_req       <= 1'b0;
            in_ep_data_done <= 1'b0;
            in_ep_stall     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            in_ep_stall     <= stall;
            in_ep_data_done <= 1'b0;
            if (flush) begin
                flush_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (!stall) begin
                        if (src_valid) begin
                            state     <= S_REQ;
                            in_ep_req <= 1'b1;
                            busy      <= 1'b1;
                            zlp       <= 1'b0;
                        end else if (flush_pend && last_full) begin
                            state     <= S_REQ;
                            in_ep_req <= 1'b1;
                            busy      <= 1'b1;
                            zlp       <= 1'b1;
                        end else if (flush_pend) begin
                            flush_pend <= flush;
                        end
                    end
                end

                S_REQ: begin
                    if (in_ep_grant) begin
                        idle_cnt <= '0;
                        if (zlp) begin
                            state           <= S_DONE;
                            in_ep_data_done <= 1'b1;
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end

                // Idle timeout fires after FLUSH_CYCLES consecutive cycles without a put.
                S_FILL: begin
                    if (put) begin
                        cnt      <= cnt + 1'b1;
                        idle_cnt <= '0;
                        if (cnt == LAST_CNT) begin
                            state           <= S_DONE;
                            in_ep_data_done <= 1'b1;
                        end
                    end else if (cnt == '0) begin
                        if (flush_pend) begin
                            if (last_full) begin
                                state           <= S_DONE;
                                in_ep_data_done <= 1'b1;
                            end else begin
                                state      <= S_IDLE;
                                in_ep_req  <= 1'b0;
                                busy       <= 1'b0;
                                flush_pend <= flush;
                            end
                        end
                    end else if (cnt == MAX_CNT || flush_pend || idle_cnt == IDLE_LAST) begin
                        state           <= S_DONE;
                        in_ep_data_done <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                // A full packet keeps a pending flush alive so that a ZLP follows it.
                S_DONE: begin
                    last_full  <= (cnt == MAX_CNT);
                    flush_pend <= flush || (flush_pend && (cnt == MAX_CNT));
                    cnt        <= '0;
                    idle_cnt   <= '0;
                    zlp        <= 1'b0;
                    in_ep_req  <= 1'b0;
                    state      <= S_WAIT_ACK;
                end

                S_WAIT_ACK: begin
                    if (in_ep_acked) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    in_ep_req <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_stream_in_ep.sv
// tb/tb_usb_stream_in_ep.sv - directed self-checking bench for usb_stream_in_ep
module tb_usb_stream_in_ep;

    localparam int MAXP = 64;
    localparam int FLC  = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_ready;
    logic       flush;
    logic       stall;
    logic       in_ep_req;
    logic       in_ep_grant;
    logic       in_ep_data_free;
    logic       in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done;
    logic       in_ep_stall;
    logic       in_ep_acked;
    logic       busy;

    usb_stream_in_ep #(.MAX_PACKET(MAXP), .CNT_W(7), .FLUSH_CYCLES(FLC)) dut (
        .clk(clk), .reset(reset),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .flush(flush), .stall(stall),
        .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant), .in_ep_data_free(in_ep_data_free),
        .in_ep_data_put(in_ep_data_put), .in_ep_data(in_ep_data),
        .in_ep_data_done(in_ep_data_done), .in_ep_stall(in_ep_stall),
        .in_ep_acked(in_ep_acked), .busy(busy)
    );

    always #5 clk = ~clk;
    assign in_ep_grant = in_ep_req;

    int checks = 0;
    int failures = 0;

    task automatic expect_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    int         cyc = 0;
    int         pkt_puts = 0;
    int         last_pkt_puts = 0;
    int         done_cnt = 0;
    int         first_put_cyc = 0;
    int         last_put_cyc = 0;
    int         done_cyc = 0;
    logic [7:0] exp_q[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pkt_puts = 0;
            end else begin
                if (in_ep_data_put) begin
                    if (pkt_puts == 0) first_put_cyc = cyc;
                    pkt_puts++;
                    last_put_cyc = cyc;
                    expect_eq("put_with_req", int'(in_ep_req), 1);
                    if (exp_q.size() == 0) begin
                        expect_eq("spurious_put", int'(in_ep_data_put), 0);
                    end else begin
                        expect_eq("put_data", int'(in_ep_data), int'(exp_q.pop_front()));
                    end
                end
                if (in_ep_data_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    last_pkt_puts = pkt_puts;
                    pkt_puts = 0;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(first + 8'(k));
    endtask

    task automatic pause_free();
        in_ep_data_free = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            expect_eq("pause_ready", int'(src_ready), 0);
            expect_eq("pause_put", int'(in_ep_data_put), 0);
            cycle();
        end
        in_ep_data_free = 1'b1;
    endtask

    task automatic send(input logic [7:0] first, input int n, input bit flush_last, input int pause_at);
        int  i;
        int  g;
        bit  acc;
        i = 0;
        g = 0;
        src_valid = 1'b1;
        src_data  = first;
        while (i < n && g < 400) begin
            flush = flush_last && (i == n - 1);
            @(negedge clk);
            acc = src_valid && src_ready;
            cycle();
            flush = 1'b0;
            if (acc) begin
                i++;
                src_data = first + 8'(i);
                if (pause_at > 0 && i == pause_at) pause_free();
            end
            g++;
        end
        src_valid = 1'b0;
        flush = 1'b0;
        expect_eq("send_count", i, n);
    endtask

    task automatic wait_done(input string tag, input int d0, input int bound);
        int g;
        g = 0;
        while (done_cnt == d0 && g < bound) begin
            cycle();
            g++;
        end
        expect_eq(tag, done_cnt, d0 + 1);
    endtask

    task automatic ack();
        in_ep_acked = 1'b1;
        cycle();
        in_ep_acked = 1'b0;
        @(negedge clk);
        expect_eq("ack_busy", int'(busy), 0);
        expect_eq("ack_req", int'(in_ep_req), 0);
        cycle();
    endtask

    int d0;

    initial begin
        reset = 1'b1;
        src_data = 8'h00;
        src_valid = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        in_ep_data_free = 1'b1;
        in_ep_acked = 1'b0;
        repeat (3) cycle();
        @(negedge clk);
        expect_eq("rst_req", int'(in_ep_req), 0);
        expect_eq("rst_ready", int'(src_ready), 0);
        expect_eq("rst_done", int'(in_ep_data_done), 0);
        expect_eq("rst_busy", int'(busy), 0);
        expect_eq("rst_stall", int'(in_ep_stall), 0);
        cycle();
        reset = 1'b0;
        cycle();

        // full packet, back-to-back
        push_exp(8'h00, 64);
        d0 = done_cnt;
        send(8'h00, 64, 1'b0, 0);
        wait_done("full_done", d0, 20);
        expect_eq("full_puts", last_pkt_puts, 64);
        expect_eq("full_span", last_put_cyc - first_put_cyc, 63);
        expect_eq("full_latency", done_cyc - last_put_cyc, 1);
        @(negedge clk);
        expect_eq("done_pulse", int'(in_ep_data_done), 0);
        expect_eq("wait_ack_req", int'(in_ep_req), 0);
        expect_eq("wait_ack_busy", int'(busy), 1);
        cycle();
        ack();

        // partial packet closed by idle timeout
        push_exp(8'h40, 10);
        d0 = done_cnt;
        send(8'h40, 10, 1'b0, 0);
        wait_done("idle_done", d0, FLC + 50);
        expect_eq("idle_puts", last_pkt_puts, 10);
        expect_eq("idle_gap", done_cyc - last_put_cyc, FLC + 1);
        ack();

        // full packet with flush on final byte, then ZLP
        push_exp(8'h80, 64);
        d0 = done_cnt;
        send(8'h80, 64, 1'b1, 0);
        wait_done("flush_full_done", d0, 20);
        expect_eq("flush_full_puts", last_pkt_puts, 64);
        d0 = done_cnt;
        ack();
        wait_done("zlp_done", d0, 20);
        expect_eq("zlp_puts", last_pkt_puts, 0);
        ack();
        repeat (5) cycle();
        @(negedge clk);
        expect_eq("no_extra_zlp", int'(in_ep_req), 0);
        expect_eq("no_extra_done", done_cnt, d0 + 1);
        cycle();

        // PE buffer full for 5 cycles after the 20th byte
        push_exp(8'hC0, 64);
        d0 = done_cnt;
        send(8'hC0, 64, 1'b0, 20);
        wait_done("pause_done", d0, 20);
        expect_eq("pause_puts", last_pkt_puts, 64);
        ack();

        // reset mid-packet discards partial data
        push_exp(8'h10, 5);
        d0 = done_cnt;
        send(8'h10, 5, 1'b0, 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        @(negedge clk);
        expect_eq("mid_rst_req", int'(in_ep_req), 0);
        expect_eq("mid_rst_put", int'(in_ep_data_put), 0);
        expect_eq("mid_rst_ready", int'(src_ready), 0);
        expect_eq("mid_rst_done", int'(in_ep_data_done), 0);
        expect_eq("mid_rst_busy", int'(busy), 0);
        expect_eq("mid_rst_data", int'(in_ep_data), 0);
        cycle();
        expect_eq("mid_rst_no_done", done_cnt, d0);
        push_exp(8'h20, 3);
        send(8'h20, 3, 1'b1, 0);
        wait_done("post_rst_done", d0, 20);
        expect_eq("post_rst_puts", last_pkt_puts, 3);
        expect_eq("flush_latency", done_cyc - last_put_cyc, 2);
        ack();

        // stall holds off a new request
        stall = 1'b1;
        src_valid = 1'b1;
        src_data = 8'h55;
        repeat (3) cycle();
        @(negedge clk);
        expect_eq("stall_out", int'(in_ep_stall), 1);
        expect_eq("stall_req", int'(in_ep_req), 0);
        expect_eq("stall_busy", int'(busy), 0);
        cycle();
        stall = 1'b0;
        cycle();
        @(negedge clk);
        expect_eq("unstall_req", int'(in_ep_req), 1);
        expect_eq("unstall_out", int'(in_ep_stall), 0);
        cycle();
        push_exp(8'h55, 1);
        d0 = done_cnt;
        send(8'h55, 1, 1'b1, 0);
        wait_done("stall_pkt_done", d0, 20);
        expect_eq("stall_pkt_puts", last_pkt_puts, 1);
        ack();

        expect_eq("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
